// File: rtl/ex_stage_m.sv
// Execute stage: single-cycle RV32I/RV64I ALU, branch and jump ops, plus optional
// iterative M-extension multiply/divide, with valid/ready handshakes and flush.
module ex_stage_m #(
  parameter int unsigned XLEN  = 32,
  parameter bit          M_EXT = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_imm,
  input  logic [4:0]      in_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd,
  output logic            out_br_taken,
  output logic [XLEN-1:0] out_br_target,
  output logic            busy
);

  localparam int unsigned SHW = $clog2(XLEN);
  localparam int unsigned DW  = 2 * XLEN;

  localparam logic [4:0] OP_ADD  = 5'd0,  OP_SUB  = 5'd1,  OP_SLL    = 5'd2,  OP_SLT   = 5'd3;
  localparam logic [4:0] OP_SLTU = 5'd4,  OP_XOR  = 5'd5,  OP_SRL    = 5'd6,  OP_SRA   = 5'd7;
  localparam logic [4:0] OP_OR   = 5'd8,  OP_AND  = 5'd9,  OP_BEQ    = 5'd10, OP_BNE   = 5'd11;
  localparam logic [4:0] OP_BLT  = 5'd12, OP_BGE  = 5'd13, OP_BLTU   = 5'd14, OP_BGEU  = 5'd15;
  localparam logic [4:0] OP_JAL  = 5'd16, OP_MUL  = 5'd17, OP_MULH   = 5'd18, OP_MULHSU = 5'd19;
  localparam logic [4:0] OP_MULHU = 5'd20, OP_DIV = 5'd21, OP_DIVU   = 5'd22, OP_REM   = 5'd23;
  localparam logic [4:0] OP_REMU = 5'd24;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_WAIT} state_e;

  state_e          state_q, state_d;
  logic [SHW-1:0]  cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic [4:0]      mop_q, mop_d;
  logic [4:0]      mrd_q, mrd_d;
  logic [XLEN-1:0] mtgt_q, mtgt_d;
  logic [XLEN-1:0] dvd_q, dvd_d;
  logic            bzero_q, bzero_d;
  logic            neg_q, neg_d;
  logic [DW-1:0]   prod_q, prod_d;
  logic [XLEN-1:0] mcand_q, mcand_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] res_q, res_d;
  logic [4:0]      rd_q, rd_d;
  logic            taken_q, taken_d;
  logic [XLEN-1:0] tgt_q, tgt_d;

  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] alu_res;
  logic            alu_tk;
  logic            is_multi, in_is_div, sa, sb, neg_in;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            out_free, accept, load_m;
  logic [XLEN:0]   mul_sum, rem_sh, div_diff;
  logic [DW-1:0]   step, fin, mul_full;
  logic [XLEN-1:0] q_mag, r_mag, mres;

  assign shamt = in_b[SHW-1:0];

  // Single-cycle result; M ops and codes 25-31 fall through to zero.
  always_comb begin
    alu_res = '0;
    alu_tk  = 1'b0;
    case (in_op)
      OP_ADD:  alu_res = in_a + in_b;
      OP_SUB:  alu_res = in_a - in_b;
      OP_SLL:  alu_res = in_a << shamt;
      OP_SLT:  alu_res = XLEN'($signed(in_a) < $signed(in_b));
      OP_SLTU: alu_res = XLEN'(in_a < in_b);
      OP_XOR:  alu_res = in_a ^ in_b;
      OP_SRL:  alu_res = in_a >> shamt;
      OP_SRA:  alu_res = XLEN'($signed(in_a) >>> shamt);
      OP_OR:   alu_res = in_a | in_b;
      OP_AND:  alu_res = in_a & in_b;
      OP_BEQ:  alu_tk  = (in_a == in_b);
      OP_BNE:  alu_tk  = (in_a != in_b);
      OP_BLT:  alu_tk  = ($signed(in_a) < $signed(in_b));
      OP_BGE:  alu_tk  = ($signed(in_a) >= $signed(in_b));
      OP_BLTU: alu_tk  = (in_a < in_b);
      OP_BGEU: alu_tk  = (in_a >= in_b);
      OP_JAL: begin
        alu_res = in_pc + XLEN'(4);
        alu_tk  = 1'b1;
      end
      default: ;
    endcase
  end

  // Operand magnitudes and result sign captured on accept of a mul/div.
  always_comb begin
    is_multi  = M_EXT && (in_op >= OP_MUL) && (in_op <= OP_REMU);
    in_is_div = (in_op >= OP_DIV);
    sa = in_a[XLEN-1] && (in_op == OP_MUL || in_op == OP_MULH || in_op == OP_MULHSU ||
                          in_op == OP_DIV || in_op == OP_REM);
    sb = in_b[XLEN-1] && (in_op == OP_MUL || in_op == OP_MULH ||
                          in_op == OP_DIV || in_op == OP_REM);
    a_mag  = sa ? -in_a : in_a;
    b_mag  = sb ? -in_b : in_b;
    neg_in = (in_op == OP_REM) ? sa : (sa ^ sb);
  end

  // One shift-add or restoring-divide step on {hi, lo}.
  always_comb begin
    mul_sum  = {1'b0, prod_q[DW-1:XLEN]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    rem_sh   = prod_q[DW-1:XLEN-1];
    div_diff = rem_sh - {1'b0, mcand_q};
    if (mop_q >= OP_DIV) begin
      step = div_diff[XLEN] ? {rem_sh[XLEN-1:0], prod_q[XLEN-2:0], 1'b0}
                            : {div_diff[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};
    end else begin
      step = {mul_sum, prod_q[XLEN-1:1]};
    end
    fin      = (state_q == S_BUSY) ? step : prod_q;
    mul_full = neg_q ? -fin : fin;
    q_mag    = fin[XLEN-1:0];
    r_mag    = fin[DW-1:XLEN];
    case (mop_q)
      OP_MUL:                     mres = mul_full[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: mres = mul_full[DW-1:XLEN];
      OP_DIV, OP_DIVU:            mres = bzero_q ? '1 : (neg_q ? -q_mag : q_mag);
      default:                    mres = bzero_q ? dvd_q : (neg_q ? -r_mag : r_mag);
    endcase
  end

  assign out_free = !valid_q || out_ready;
  assign in_ready = rst && (state_q == S_IDLE) && out_free && !flush;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mop_d   = mop_q;
    mrd_d   = mrd_q;
    mtgt_d  = mtgt_q;
    dvd_d   = dvd_q;
    bzero_d = bzero_q;
    neg_d   = neg_q;
    prod_d  = prod_q;
    mcand_d = mcand_q;
    valid_d = valid_q && !out_ready;
    res_d   = res_q;
    rd_d    = rd_q;
    taken_d = taken_q;
    tgt_d   = tgt_q;
    load_m  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept && is_multi) begin
          state_d = S_BUSY;
          cnt_d   = '0;
          mop_d   = in_op;
          mrd_d   = in_rd;
          mtgt_d  = in_pc + in_imm;
          dvd_d   = in_a;
          bzero_d = (in_b == '0);
          neg_d   = neg_in;
          prod_d  = in_is_div ? {XLEN'(0), a_mag} : {XLEN'(0), b_mag};
          mcand_d = in_is_div ? b_mag : a_mag;
        end else if (accept) begin
          valid_d = 1'b1;
          res_d   = alu_res;
          rd_d    = in_rd;
          taken_d = alu_tk;
          tgt_d   = in_pc + in_imm;
        end
      end
      S_BUSY: begin
        prod_d = step;
        cnt_d  = cnt_q + SHW'(1);
        if (cnt_q == SHW'(XLEN - 1)) begin
          if (out_free) begin
            state_d = S_IDLE;
            load_m  = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (out_free) begin
          state_d = S_IDLE;
          load_m  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load_m) begin
      valid_d = 1'b1;
      res_d   = mres;
      rd_d    = mrd_q;
      taken_d = 1'b0;
      tgt_d   = mtgt_q;
    end

    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      valid_d = 1'b0;
    end

    busy_d = (state_d == S_BUSY);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      mop_q   <= '0;
      mrd_q   <= '0;
      mtgt_q  <= '0;
      dvd_q   <= '0;
      bzero_q <= 1'b0;
      neg_q   <= 1'b0;
      prod_q  <= '0;
      mcand_q <= '0;
      valid_q <= 1'b0;
      res_q   <= '0;
      rd_q    <= '0;
      taken_q <= 1'b0;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      mop_q   <= mop_d;
      mrd_q   <= mrd_d;
      mtgt_q  <= mtgt_d;
      dvd_q   <= dvd_d;
      bzero_q <= bzero_d;
      neg_q   <= neg_d;
      prod_q  <= prod_d;
      mcand_q <= mcand_d;
      valid_q <= valid_d;
      res_q   <= res_d;
      rd_q    <= rd_d;
      taken_q <= taken_d;
      tgt_q   <= tgt_d;
    end
  end

  assign out_valid     = valid_q && !flush;
  assign out_result    = res_q;
  assign out_rd        = rd_q;
  assign out_br_taken  = taken_q;
  assign out_br_target = tgt_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_ex_stage_m.sv
// Bench for ex_stage_m (XLEN=32, M_EXT=1): directed plan items plus random ops
// checked against an arithmetic reference model.
module tb_ex_stage_m;

  localparam logic [4:0] ADD = 5'd0, SUB = 5'd1, SLL = 5'd2, SLT = 5'd3, SLTU = 5'd4;
  localparam logic [4:0] XOR = 5'd5, SRA = 5'd7, BLT = 5'd12, BGEU = 5'd15, JAL = 5'd16;
  localparam logic [4:0] MUL = 5'd17, MULHU = 5'd20, DIV = 5'd21, REM = 5'd23;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, out_br_taken, busy;
  logic [4:0]  in_op, in_rd, out_rd;
  logic [31:0] in_a, in_b, in_pc, in_imm, out_result, out_br_target;

  int ncmp  = 0;
  int nfail = 0;

  ex_stage_m #(.XLEN(32), .M_EXT(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_pc(in_pc), .in_imm(in_imm), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rd(out_rd), .out_br_taken(out_br_taken), .out_br_target(out_br_target),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // RISC-V semantics written directly with 32/64-bit integer arithmetic.
  function automatic void ref_model(input logic [4:0] op, input logic [31:0] a, b, pc,
                                    output logic [31:0] res, output logic tk);
    int          sa, sb;
    longint      p;
    logic [63:0] pu;
    sa  = a;
    sb  = b;
    res = 32'd0;
    tk  = 1'b0;
    case (op)
      5'd0:  res = a + b;
      5'd1:  res = a - b;
      5'd2:  res = a << b[4:0];
      5'd3:  res = 32'(sa < sb);
      5'd4:  res = 32'(a < b);
      5'd5:  res = a ^ b;
      5'd6:  res = a >> b[4:0];
      5'd7:  res = 32'(sa >>> b[4:0]);
      5'd8:  res = a | b;
      5'd9:  res = a & b;
      5'd10: tk = (a == b);
      5'd11: tk = (a != b);
      5'd12: tk = (sa < sb);
      5'd13: tk = (sa >= sb);
      5'd14: tk = (a < b);
      5'd15: tk = (a >= b);
      5'd16: begin res = pc + 32'd4; tk = 1'b1; end
      5'd17: begin p = longint'(sa) * longint'(sb); res = p[31:0]; end
      5'd18: begin p = longint'(sa) * longint'(sb); res = p[63:32]; end
      5'd19: begin p = longint'(sa) * longint'({32'd0, b}); res = p[63:32]; end
      5'd20: begin pu = {32'd0, a} * {32'd0, b}; res = pu[63:32]; end
      5'd21: if (b == 0) res = 32'hFFFF_FFFF;
             else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = a;
             else res = 32'(sa / sb);
      5'd22: res = (b == 0) ? 32'hFFFF_FFFF : a / b;
      5'd23: if (b == 0) res = a;
             else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = 32'd0;
             else res = 32'(sa % sb);
      5'd24: res = (b == 0) ? a : a % b;
      default: ;
    endcase
  endfunction

  // Issue one op with out_ready=1 and check everything about its completion.
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, b, pc, imm,
                        input logic [4:0] rd, input string tag,
                        output logic [31:0] obs_res, output logic obs_tk);
    logic [31:0] er;
    logic        et;
    int          w, k, nb, nr;
    bit          multi;
    ref_model(op, a, b, pc, er, et);
    multi = (op >= 5'd17 && op <= 5'd24);
    @(negedge clk);
    in_op = op; in_a = a; in_b = b; in_pc = pc; in_imm = imm; in_rd = rd; in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 100) begin @(negedge clk); w++; end
    check({tag, " in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    k = 0; nb = 0; nr = 0;
    do begin
      @(negedge clk);
      k++;
      if (!out_valid) begin
        if (busy) nb++;
        if (in_ready) nr++;
      end
    end while (!out_valid && k < 100);
    obs_res = out_result;
    obs_tk  = out_br_taken;
    check({tag, " latency"}, 32'(k), multi ? 32'd33 : 32'd1);
    check({tag, " busy cycles"}, 32'(nb), multi ? 32'd32 : 32'd0);
    check({tag, " ready while busy"}, 32'(nr), 32'd0);
    check({tag, " result"}, out_result, er);
    check({tag, " rd"}, 32'(out_rd), 32'(rd));
    check({tag, " taken"}, 32'(out_br_taken), 32'(et));
    check({tag, " target"}, out_br_target, pc + imm);
  endtask

  initial begin
    logic [31:0] r, xr;
    logic        t, xt;
    int          cnt;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_op = '0; in_a = '0; in_b = '0; in_pc = '0; in_imm = '0; in_rd = '0;

    // Reset acts without a clock edge.
    #2 rst = 1'b0;
    #1;
    check("reset in_ready", 32'(in_ready), 32'd0);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset out_result", out_result, 32'd0);
    check("reset out_br_target", out_br_target, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    run_op(ADD, 32'd5, 32'd7, 32'h0, 32'h0, 5'd3, "add", r, t);
    check("add plan", r, 32'd12);
    run_op(SUB, 32'd5, 32'd7, 32'h0, 32'h0, 5'd4, "sub", r, t);
    check("sub plan", r, 32'hFFFF_FFFE);
    run_op(SRA, 32'h8000_0000, 32'd4, 32'h0, 32'h0, 5'd5, "sra", r, t);
    check("sra plan", r, 32'hF800_0000);
    run_op(SLT, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0, 5'd6, "slt", r, t);
    check("slt plan", r, 32'd1);
    run_op(SLTU, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0, 5'd6, "sltu", r, t);
    check("sltu plan", r, 32'd0);
    run_op(SLL, 32'h0000_0003, 32'd33, 32'h0, 32'h0, 5'd7, "sll33", r, t);
    check("sll33 plan", r, 32'h0000_0006);
    run_op(BLT, -32'sd3, 32'd2, 32'h100, 32'h20, 5'd0, "blt", r, t);
    check("blt plan taken", 32'(t), 32'd1);
    check("blt plan target", out_br_target, 32'h120);
    run_op(BGEU, -32'sd3, 32'd2, 32'h100, 32'h20, 5'd0, "bgeu", r, t);
    check("bgeu plan taken", 32'(t), 32'd1);
    run_op(JAL, 32'd0, 32'd0, 32'h100, 32'h20, 5'd1, "jal", r, t);
    check("jal plan", r, 32'h104);
    run_op(MUL, 32'd7, -32'sd3, 32'h0, 32'h0, 5'd8, "mul", r, t);
    check("mul plan", r, 32'hFFFF_FFEB);
    run_op(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 5'd9, "mulhu", r, t);
    check("mulhu plan", r, 32'hFFFF_FFFE);
    run_op(DIV, 32'd7, 32'd0, 32'h0, 32'h0, 5'd10, "div0", r, t);
    check("div0 plan", r, 32'hFFFF_FFFF);
    run_op(REM, 32'd7, 32'd0, 32'h0, 32'h0, 5'd11, "rem0", r, t);
    check("rem0 plan", r, 32'd7);
    run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h0, 5'd12, "divovf", r, t);
    check("divovf plan", r, 32'h8000_0000);
    run_op(REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h0, 5'd13, "removf", r, t);
    check("removf plan", r, 32'd0);

    // Backpressure: ADD held, XOR waits, then drain and accept on one edge.
    ref_model(ADD, 32'h11, 32'h22, 32'h0, r, t);
    ref_model(XOR, 32'hF0F0_1234, 32'h0FF0_4321, 32'h0, xr, xt);
    @(negedge clk);
    out_ready = 1'b0;
    in_op = ADD; in_a = 32'h11; in_b = 32'h22; in_rd = 5'd14; in_valid = 1'b1;
    check("bp add ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_op = XOR; in_a = 32'hF0F0_1234; in_b = 32'h0FF0_4321; in_rd = 5'd15;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp xor blocked", 32'(in_ready), 32'd0);
      check("bp hold valid", 32'(out_valid), 32'd1);
      check("bp hold result", out_result, r);
      check("bp hold rd", 32'(out_rd), 32'd14);
    end
    out_ready = 1'b1;
    #1 check("bp ready on drain", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("bp xor valid", 32'(out_valid), 32'd1);
    check("bp xor result", out_result, xr);
    check("bp xor rd", 32'(out_rd), 32'd15);
    @(negedge clk);
    check("bp xor drained", 32'(out_valid), 32'd0);

    // MUL completing while the consumer stalls holds until drained.
    ref_model(MUL, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0, r, t);
    @(negedge clk);
    in_op = MUL; in_a = 32'h1234_5678; in_b = 32'h9ABC_DEF0; in_rd = 5'd16; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0; out_ready = 1'b0;
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (!out_valid && cnt < 100);
    check("mul stall latency", 32'(cnt), 32'd33);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mul stall hold", out_result, r);
      check("mul stall valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("mul stall drained", 32'(out_valid), 32'd0);

    // Flush ten cycles into a DIV.
    @(negedge clk);
    in_op = DIV; in_a = 32'd1000; in_b = 32'd7; in_rd = 5'd17; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    #1 check("flush in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush busy", 32'(busy), 32'd0);
    check("flush in_ready after", 32'(in_ready), 32'd1);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin @(negedge clk); if (out_valid) cnt++; end
    check("flush no result", 32'(cnt), 32'd0);
    run_op(ADD, 32'd40, 32'd2, 32'h0, 32'h4, 5'd18, "add after flush", r, t);

    // Asynchronous reset in the middle of a MUL.
    @(negedge clk);
    in_op = MUL; in_a = 32'd9; in_b = 32'd9; in_rd = 5'd19; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("mid rst out_valid", 32'(out_valid), 32'd0);
    check("mid rst busy", 32'(busy), 32'd0);
    check("mid rst in_ready", 32'(in_ready), 32'd0);
    check("mid rst out_result", out_result, 32'd0);
    check("mid rst out_rd", 32'(out_rd), 32'd0);
    check("mid rst out_br_target", out_br_target, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin @(negedge clk); if (out_valid) cnt++; end
    check("post rst no stale", 32'(cnt), 32'd0);
    check("post rst ready", 32'(in_ready), 32'd1);
    run_op(ADD, 32'd1, 32'd2, 32'h0, 32'h0, 5'd20, "add after rst", r, t);

    // Random mix including illegal codes and zero divisors.
    for (int i = 0; i < 60; i++) begin
      logic [4:0]  op, rd;
      logic [31:0] a, b, pc, imm;
      op  = 5'($urandom_range(0, 31));
      a   = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : 32'($urandom);
      b   = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom);
      if ($urandom_range(0, 7) == 0) b = 32'hFFFF_FFFF;
      pc  = 32'($urandom);
      imm = 32'($urandom);
      rd  = 5'($urandom_range(0, 31));
      run_op(op, a, b, pc, imm, rd, "rnd", r, t);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/ex_stage_m.md
# ex_stage_m

Parametrised execute stage for the RISC-V core, sitting between decode (ID) and memory (MEM). Executes single-cycle RV32I ALU, branch and jump operations, and optionally multi-cycle RV M-extension multiply/divide using an iterative datapath. Uses valid/ready handshakes on both sides, holds one result in an output register under backpressure, and supports pipeline flush.

## Interface
- XLEN, 32, datapath width; must be 32 or 64.
- M_EXT, 1, 1 enables multiply/divide ops 17–24; 0 treats them as illegal.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous kill of the in-flight and held operation.
- in_valid  in  1  ID presents an operation.
- in_ready  out  1  EX accepts an operation this cycle.
- in_op  in  5  operation code; see Operation.
- in_a, in_b  in  XLEN  source operands, already forwarded.
- in_pc, in_imm  in  XLEN  instruction PC and branch/jump offset.
- in_rd  in  5  destination register index.
- out_valid  out  1  result available to MEM.
- out_ready  in  1  MEM accepts the result.
- out_result  out  XLEN  ALU result, link address, or mul/div result.
- out_rd  out  5  destination register, carried with the result.
- out_br_taken  out  1  branch/jump taken.
- out_br_target  out  XLEN  pc + imm, modulo 2^XLEN.
- busy  out  1  high while a multi-cycle op iterates.

## Operation
- Op codes:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND.
  - 10 BEQ, 11 BNE, 12 BLT, 13 BGE, 14 BLTU, 15 BGEU, 16 JAL.
  - 17 MUL, 18 MULH, 19 MULHSU, 20 MULHU, 21 DIV, 22 DIVU, 23 REM, 24 REMU.
  - 25–31 are illegal.
- Shifts use in_b[log2(XLEN)-1:0] as the amount. All arithmetic wraps modulo 2^XLEN.
- Branches:
  - out_result = 0; out_br_taken = condition; out_br_target = in_pc + in_imm.
  - Any op with out_br_taken = 0 still drives out_br_target.
- JAL: out_result = in_pc + 4; out_br_taken = 1.
- Illegal ops (including ops 17–24 with M_EXT=0) complete as single-cycle ops with out_result = 0 and out_br_taken = 0.
- Multiply: shift-add over XLEN iterations on magnitudes, with sign correction per variant. MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
- Divide: restoring, XLEN iterations.
  - Divide by zero: quotient all ones, remainder = dividend.
  - Signed overflow (most-negative / −1): quotient = dividend, remainder = 0.
  - Both cases still take full latency.
- FSM:
  - IDLE: accepting. An accepted multi-cycle op goes to BUSY. Single-cycle ops load the output register directly.
  - BUSY: counter runs 0..XLEN−1. At XLEN−1, go to IDLE if the output register is free (or draining this cycle) and load the result; otherwise go to WAIT.
  - WAIT: hold the result; load it and go to IDLE when the output register frees.
- in_ready = rst & state==IDLE & (!valid_q | out_ready) & !flush.
- out_valid = valid_q & !flush. A transfer completes only when out_valid & out_ready.
- Flush clears valid_q and returns the FSM to IDLE at the next edge. An op presented on a flush cycle is not accepted.

## Timing
- Reset (rst low): state=IDLE, counter=0; all outputs 0, in_ready=0, busy=0. Effective immediately; no clock required.
- Single-cycle op accepted at edge N: out_valid high after edge N+1, i.e. latency 1. Back-to-back throughput is 1 op/cycle when out_ready=1.
- Multi-cycle op accepted at edge N:
  - busy high from edge N+1 through edge N+XLEN.
  - out_valid high after edge N+XLEN+1 (33 cycles for XLEN=32) if unstalled.
  - in_ready low throughout.
- Output register holds out_result, out_rd, out_br_taken and out_br_target stable while out_valid & !out_ready.
- Simultaneous drain and load: with out_ready=1 and a new accept on the same edge, the register reloads with no bubble.
- Reset mid-operation: the iteration is abandoned; after rst rises, the FSM is in IDLE with no stale out_valid.

## Test plan
- ADD: a=5, b=7, rd=3 accepted at cycle 0 -> out_valid at cycle 1, out_result=12, out_rd=3, out_br_taken=0. Then SUB 5−7 -> 0xFFFFFFFE.
- Shift/compare:
  - SRA 0x80000000 by 4 -> 0xF8000000.
  - SLT a=0xFFFFFFFF, b=1 -> 1; SLTU with the same operands -> 0.
  - SLL by b=33 -> shift by 1.
- Branch/jump, pc=0x100, imm=0x20:
  - BLT a=−3, b=2 -> taken=1, target=0x120, result=0.
  - BGEU with the same operands -> taken=1.
  - JAL -> result=0x104, taken=1.
- M-extension (M_EXT=1):
  - MUL 7 × −3 -> 0xFFFFFFEB, with out_valid exactly 33 cycles after accept, busy high for 32 cycles and in_ready low throughout.
  - MULHU 0xFFFFFFFF² -> 0xFFFFFFFE.
  - DIV 7/0 -> 0xFFFFFFFF; REM 7/0 -> 7.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same -> 0.
- Backpressure:
  - out_ready=0, issue ADD then XOR: XOR is not accepted (in_ready=0), and the ADD result holds stable for 5 cycles.
  - Raise out_ready: ADD drains and XOR is accepted on the same edge.
  - A MUL finishing while the output is held enters WAIT and emits only after the drain.
- Flush/reset:
  - Flush at cycle 10 of a DIV -> no out_valid, busy=0 and in_ready=1 on the next cycle.
  - A new ADD then completes normally.
  - rst asserted mid-MUL -> all outputs 0 immediately, and no stale result after release.
